// File: rtl/breath_led_pwm.sv
// Breathing-LED PWM driver: duty cycle ramps down then up via cascaded tick / period / ramp counters.
// Latency: led is registered and reflects the counter state of the previous sys_clk cycle.
// Backpressure: none; free-running with no handshakes.
module breath_led_pwm #(
    parameter logic [6:0] CNT_2US_MAX = 7'd100,
    parameter logic [9:0] CNT_2MS_MAX = 10'd1000,
    parameter logic [9:0] CNT_2S_MAX  = 10'd1000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic led
);

    localparam int US_W  = $bits(CNT_2US_MAX);
    localparam int MS_W  = $bits(CNT_2MS_MAX);
    localparam int S_W   = $bits(CNT_2S_MAX);
    localparam int CMP_W = (MS_W > S_W) ? MS_W : S_W;

    localparam logic [US_W-1:0] US_LAST = US_W'(CNT_2US_MAX - 1'b1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(CNT_2MS_MAX - 1'b1);
    localparam logic [S_W-1:0]  S_LAST  = S_W'(CNT_2S_MAX - 1'b1);

    logic [US_W-1:0]  cnt_2us;
    logic [MS_W-1:0]  cnt_2ms;
    logic [S_W-1:0]   cnt_2s;
    logic             dir;

    logic             tick_2us;
    logic             tick_2ms;
    logic             phase_end;
    logic [CMP_W-1:0] level_ext;
    logic [CMP_W-1:0] step_ext;
    logic             led_on;

    assign tick_2us  = (cnt_2us == US_LAST);
    assign tick_2ms  = tick_2us && (cnt_2ms == MS_LAST);
    assign phase_end = tick_2ms && (cnt_2s == S_LAST);

    // Fine tick: with CNT_2US_MAX = 1 the counter sits at 0 and ticks every cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_2us <= '0;
        end else if (tick_2us) begin
            cnt_2us <= '0;
        end else begin
            cnt_2us <= cnt_2us + 1'b1;
        end
    end

    // PWM position within the period; doubles as the duty level being compared.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_2ms <= '0;
        end else if (tick_2ms) begin
            cnt_2ms <= '0;
        end else if (tick_2us) begin
            cnt_2ms <= cnt_2ms + 1'b1;
        end
    end

    // Ramp step: one step per PWM period.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_2s <= '0;
        end else if (phase_end) begin
            cnt_2s <= '0;
        end else if (tick_2ms) begin
            cnt_2s <= cnt_2s + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dir <= 1'b0;
        end else if (phase_end) begin
            dir <= ~dir;
        end
    end

    assign level_ext = CMP_W'(cnt_2ms);
    assign step_ext  = CMP_W'(cnt_2s);

    // dir=0 fades out (lit while level > step), dir=1 fades in (lit while level <= step).
    always_comb begin
        led_on = 1'b0;
        if (dir) begin
            led_on = (level_ext <= step_ext);
        end else begin
            led_on = (level_ext > step_ext);
        end
    end

    // Active-low LED pin, dark in reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led <= 1'b1;
        end else begin
            led <= ~led_on;
        end
    end

endmodule

// File: tb/tb_breath_led_pwm.sv
// Directed bench for breath_led_pwm: small-parameter ramp/phase checks plus a default-parameter smoke test.
module tb_breath_led_pwm;

    logic sys_clk;
    logic sys_rst_n;
    logic led;
    logic def_rst_n;
    logic def_led;

    int tests_run;
    int tests_failed;
    int cyc;

    breath_led_pwm #(
        .CNT_2US_MAX(7'd1),
        .CNT_2MS_MAX(10'd10),
        .CNT_2S_MAX (10'd10)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .led      (led)
    );

    breath_led_pwm dut_def (
        .sys_clk  (sys_clk),
        .sys_rst_n(def_rst_n),
        .led      (def_led)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    // Edges seen since the last reset release of the small instance.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    // Independent behavioural reference: led after edge n reflects state m = n-1.
    function automatic logic exp_led(input int m);
        int ms, s, d;
        ms = m % 10;
        s  = (m / 10) % 10;
        d  = (m / 100) % 2;
        if (d == 1) return (ms <= s) ? 1'b0 : 1'b1;
        return (ms > s) ? 1'b0 : 1'b1;
    endfunction

    task automatic observe_period(output int lit);
        lit = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (led === 1'b0) lit++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge sys_clk);
            tests_run++;
            if (led !== 1'b1 || dut.cnt_2us !== '0 || dut.cnt_2ms !== '0 ||
                dut.cnt_2s !== '0 || dut.dir !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold t=%0t: led=%b cnt_2ms=%0d cnt_2s=%0d dir=%b, required led=1 all zero",
                         $time, led, dut.cnt_2ms, dut.cnt_2s, dut.dir);
            end
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_first_period();
        int lit;
        logic want;
        lit = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            want = (i == 1) ? 1'b1 : 1'b0;
            if (led === 1'b0) lit++;
            tests_run++;
            if (led !== want) begin
                tests_failed++;
                $display("FAIL first_period cycle %0d: led=%b, required %b", i, led, want);
            end
        end
        tests_run++;
        if (lit !== 9) begin
            tests_failed++;
            $display("FAIL first_period_lit: lit=%0d, required 9", lit);
        end
    endtask

    task automatic test_fade_out();
        int lit;
        for (int k = 1; k < 10; k++) begin
            observe_period(lit);
            tests_run++;
            if (lit !== 9 - k) begin
                tests_failed++;
                $display("FAIL fade_out period %0d: lit=%0d, required %0d", k, lit, 9 - k);
            end
        end
    endtask

    task automatic test_phase_toggle();
        tests_run++;
        if (cyc !== 100 || dut.dir !== 1'b1 || dut.cnt_2s !== '0 || dut.cnt_2ms !== '0) begin
            tests_failed++;
            $display("FAIL phase_toggle: cyc=%0d dir=%b cnt_2s=%0d cnt_2ms=%0d, required cyc=100 dir=1 cnt_2s=0 cnt_2ms=0",
                     cyc, dut.dir, dut.cnt_2s, dut.cnt_2ms);
        end
    endtask

    task automatic test_fade_in();
        int lit;
        for (int k = 0; k < 10; k++) begin
            observe_period(lit);
            tests_run++;
            if (lit !== k + 1) begin
                tests_failed++;
                $display("FAIL fade_in period %0d: lit=%0d, required %0d", k, lit, k + 1);
            end
        end
        tests_run++;
        if (cyc !== 200 || dut.dir !== 1'b0 || dut.cnt_2s !== '0) begin
            tests_failed++;
            $display("FAIL dir_return: cyc=%0d dir=%b cnt_2s=%0d, required cyc=200 dir=0 cnt_2s=0",
                     cyc, dut.dir, dut.cnt_2s);
        end
    endtask

    task automatic test_repeat();
        logic want;
        for (int n = 201; n <= 400; n++) begin
            @(negedge sys_clk);
            want = exp_led((n - 1) % 200);
            tests_run++;
            if (led !== want) begin
                tests_failed++;
                $display("FAIL repeat cycle %0d: led=%b, required %b", n, led, want);
            end
        end
    endtask

    task automatic test_async_reset();
        tests_run++;
        if (led !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_pre: led=%b, required 0", led);
        end
        #3 sys_rst_n = 1'b0;
        #1;
        tests_run++;
        if (led !== 1'b1 || dut.cnt_2ms !== '0 || dut.cnt_2s !== '0 || dut.dir !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: led=%b cnt_2ms=%0d cnt_2s=%0d dir=%b, required led=1 all zero",
                     led, dut.cnt_2ms, dut.cnt_2s, dut.dir);
        end
        @(negedge sys_clk);
        tests_run++;
        if (led !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_hold: led=%b, required 1", led);
        end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_restart();
        int lit;
        observe_period(lit);
        tests_run++;
        if (lit !== 9) begin
            tests_failed++;
            $display("FAIL restart_lit: lit=%0d, required 9", lit);
        end
    endtask

    task automatic test_default();
        @(negedge sys_clk);
        def_rst_n = 1'b1;
        repeat (99) @(negedge sys_clk);
        tests_run++;
        if (dut_def.cnt_2us !== 7'd99 || dut_def.cnt_2ms !== 10'd0 || def_led !== 1'b1) begin
            tests_failed++;
            $display("FAIL default_99: cnt_2us=%0d cnt_2ms=%0d led=%b, required 99 0 1",
                     dut_def.cnt_2us, dut_def.cnt_2ms, def_led);
        end
        @(negedge sys_clk);
        tests_run++;
        if (dut_def.cnt_2us !== 7'd0 || dut_def.cnt_2ms !== 10'd1 || def_led !== 1'b1) begin
            tests_failed++;
            $display("FAIL default_100: cnt_2us=%0d cnt_2ms=%0d led=%b, required 0 1 1",
                     dut_def.cnt_2us, dut_def.cnt_2ms, def_led);
        end
        @(negedge sys_clk);
        tests_run++;
        if (def_led !== 1'b0) begin
            tests_failed++;
            $display("FAIL default_lit: led=%b, required 0", def_led);
        end
        repeat (99) @(negedge sys_clk);
        tests_run++;
        if (dut_def.cnt_2ms !== 10'd2 || dut_def.cnt_2us !== 7'd0 || dut_def.cnt_2s !== 10'd0) begin
            tests_failed++;
            $display("FAIL default_200: cnt_2ms=%0d cnt_2us=%0d cnt_2s=%0d, required 2 0 0",
                     dut_def.cnt_2ms, dut_def.cnt_2us, dut_def.cnt_2s);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        sys_rst_n    = 1'b0;
        def_rst_n    = 1'b0;
        test_reset();
        test_first_period();
        test_fade_out();
        test_phase_toggle();
        test_fade_in();
        test_repeat();
        test_async_reset();
        test_restart();
        test_default();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
